// File: rtl/logic_reduce_pkg.sv
// Shared encodings for the sequential bitwise reducer: operator codes, FSM states
// and the helpers that split an operator into its base gate and final inversion.
package logic_reduce_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BASE_AND = 2'd0,
        BASE_OR  = 2'd1,
        BASE_XOR = 2'd2
    } base_t;

    // Codes 6 and 7 are undefined and behave as NOR.
    function automatic logic inv_of(input logic [2:0] op);
        return (op >= OP_NAND);
    endfunction

    function automatic base_t base_of(input logic [2:0] op);
        base_t b;
        case (op)
            OP_AND, OP_NAND: b = BASE_AND;
            OP_XOR, OP_XNOR: b = BASE_XOR;
            default:         b = BASE_OR;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/logic_reduce_alu.sv
// Combinational base gate of the reducer: applies AND, OR or XOR bitwise to two operands.
module logic_reduce_alu
    import logic_reduce_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  base_t            base_op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (base_op)
            BASE_AND: y = a & b;
            BASE_OR:  y = a | b;
            BASE_XOR: y = a ^ b;
            default:  y = a | b;
        endcase
    end

endmodule

// File: rtl/logic_reduce_seq.sv
// Folds a valid/ready stream of WIDTH-bit operands through a selectable bitwise op and
// hands back one result per reduction. Define LOGIC_REDUCE_COUNT_EN to add out_count.
module logic_reduce_seq
    import logic_reduce_pkg::*;
#(
    parameter int WIDTH = 8
`ifdef LOGIC_REDUCE_COUNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef LOGIC_REDUCE_COUNT_EN
    ,
    output logic [CNT_W-1:0] out_count
`endif
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] alu_y;
    logic             accept;
    logic             deliver;

    assign in_ready  = (state_q != ST_DONE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = out_data_q;
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;

    logic_reduce_alu #(.WIDTH(WIDTH)) u_alu (
        .a       (acc_q),
        .b       (in_data),
        .base_op (base_of(op_q)),
        .y       (alu_y)
    );

    // The N-variants fold with their base gate and invert only once, at the final operand.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        op_d       = op_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    acc_d = in_data;
                    op_d  = op;
                    if (in_last) begin
                        out_data_d = in_data ^ {WIDTH{inv_of(op)}};
                        state_d    = ST_DONE;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    acc_d = alu_y;
                    if (in_last) begin
                        out_data_d = alu_y ^ {WIDTH{inv_of(op_q)}};
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (deliver) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            op_q       <= OP_NOR;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            op_q       <= op_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef LOGIC_REDUCE_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating: a long reduction reports the maximum count rather than wrapping.
    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign out_count = out_count_q;

    always_comb begin
        cnt_d       = cnt_q;
        out_count_d = out_count_q;
        if (accept) begin
            if (state_q == ST_IDLE) begin
                cnt_d = CNT_W'(1);
            end else begin
                cnt_d = cnt_inc;
            end
            if (in_last) begin
                out_count_d = cnt_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            out_count_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            out_count_q <= out_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_logic_reduce_seq.sv
// Bench for logic_reduce_seq: queue-based reference model checked every cycle, plus directed
// reductions with literal expectations. Define LOGIC_REDUCE_COUNT_EN to cover out_count.
module tb_logic_reduce_seq;

    localparam int W = 8;
`ifdef LOGIC_REDUCE_COUNT_EN
    localparam int CW = 2;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   op = 3'd0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
`ifdef LOGIC_REDUCE_COUNT_EN
    logic [CW-1:0] out_count;
`endif

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef LOGIC_REDUCE_COUNT_EN
    logic_reduce_seq #(.WIDTH(W), .CNT_W(CW)) dut (
`else
    logic_reduce_seq #(.WIDTH(W)) dut (
`endif
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef LOGIC_REDUCE_COUNT_EN
        ,
        .out_count (out_count)
`endif
    );

    // Reference model: collect the operands of a reduction, fold them all once in_last arrives.
    logic [W-1:0] opnds[$];
    logic [2:0]   cur_op;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    int           m_count = 0;
    logic         chk_en  = 1'b0;

    function automatic logic [W-1:0] fold_all(input logic [2:0] o);
        logic [W-1:0] r;
        r = opnds[0];
        for (int i = 1; i < opnds.size(); i++) begin
            case (o)
                3'd0, 3'd3: r = r & opnds[i];
                3'd2, 3'd5: r = r ^ opnds[i];
                default:    r = r | opnds[i];
            endcase
        end
        if (o >= 3'd3) r = ~r;
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_count = 0;
            opnds.delete();
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (in_valid) begin
            if (opnds.size() == 0) cur_op = op;
            opnds.push_back(in_data);
            if (in_last) begin
                m_data  = fold_all(cur_op);
`ifdef LOGIC_REDUCE_COUNT_EN
                m_count = (opnds.size() > (2**CW - 1)) ? (2**CW - 1) : opnds.size();
`else
                m_count = opnds.size();
`endif
                m_valid = 1'b1;
                opnds.delete();
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle away from the clock edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_in_ready", int'(in_ready), int'(!m_valid));
            check("cyc_out_valid", int'(out_valid), int'(m_valid));
            check("cyc_out_data", int'(out_data), int'(m_data));
`ifdef LOGIC_REDUCE_COUNT_EN
            check("cyc_out_count", int'(out_count), m_count);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends n operands back to back (in_ready is high in IDLE/ACCUM), then checks latency and result.
    task automatic reduce(input string name, input logic [2:0] o, input int n,
                          input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2,
                          input logic [W-1:0] d3, input logic [W-1:0] d4,
                          input logic [W-1:0] expv, input int expc);
        logic [W-1:0] d[5];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3; d[4] = d4;
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            op       = o;
            in_valid = 1'b1;
            in_data  = d[i];
            in_last  = (i == n - 1);
            check({name, "_pre_valid"}, int'(out_valid), 0);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({name, "_valid"}, int'(out_valid), 1);
        check({name, "_data"}, int'(out_data), int'(expv));
`ifdef LOGIC_REDUCE_COUNT_EN
        if (expc >= 0) check({name, "_count"}, int'(out_count), expc);
`else
        if (expc < -1) check({name, "_count"}, expc, -1);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, "_drained"}, int'(out_valid), 0);
        check({name, "_ready"}, int'(in_ready), 1);
        check({name, "_hold"}, int'(out_data), int'(expv));
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        rst    = 1'b0;
        chk_en = 1'b1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);

        reduce("nor_zero", 3'd4, 2, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 2);
        reduce("nor_comp", 3'd4, 2, 8'h0F, 8'hF0, 0, 0, 0, 8'h00, 2);
        reduce("and3", 3'd0, 3, 8'hFF, 8'h3C, 8'hF0, 0, 0, 8'h30, 3);
        reduce("xor3", 3'd2, 3, 8'h01, 8'h02, 8'h04, 0, 0, 8'h07, 3);
        reduce("xnor2", 3'd5, 2, 8'hAA, 8'h55, 0, 0, 0, 8'h00, 2);
        reduce("op7", 3'd7, 2, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 2);
        reduce("nand1", 3'd3, 1, 8'hA5, 0, 0, 0, 0, 8'h5A, 1);
        reduce("or1", 3'd1, 1, 8'hA5, 0, 0, 0, 0, 8'hA5, 1);

        // Gap in ACCUM, then backpressure with ignored operand pulses.
        op = 3'd1; in_valid = 1'b1; in_data = 8'h12; in_last = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        in_valid = 1'b1; in_data = 8'h34; in_last = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_data  = 8'hC3;
            in_last  = 1'b1;
            op       = 3'd0;
            check("bp_valid", int'(out_valid), 1);
            check("bp_data", int'(out_data), 8'h36);
            check("bp_in_ready", int'(in_ready), 0);
            step();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_release_ready", int'(in_ready), 1);

        // Reset after 2 of 3 operands must leave no stale accumulator.
        op = 3'd0; in_valid = 1'b1; in_data = 8'h0F; in_last = 1'b0;
        step();
        in_data = 8'hFF;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_ready", int'(in_ready), 1);
        check("midrst_data", int'(out_data), 0);
        reduce("post_rst_or", 3'd1, 2, 8'h01, 8'h80, 0, 0, 0, 8'h81, 2);

        // Reset while a result is waiting.
        op = 3'd2; in_valid = 1'b1; in_data = 8'h0F; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        check("done_rst_pre", int'(out_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("done_rst_valid", int'(out_valid), 0);
        check("done_rst_data", int'(out_data), 0);

`ifdef LOGIC_REDUCE_COUNT_EN
        reduce("cnt_sat", 3'd0, 5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 3);
        reduce("cnt_two", 3'd1, 2, 8'h10, 8'h01, 0, 0, 0, 8'h11, 2);
        // Op change on the second operand is ignored: XOR of 01,03 = 02.
        op = 3'd2; in_valid = 1'b1; in_data = 8'h01; in_last = 1'b0;
        step();
        op = 3'd0; in_data = 8'h03; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        check("opchg_data", int'(out_data), 8'h02);
        check("opchg_count", int'(out_count), 2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
`endif

        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
